// File: rtl/div_ctrl.sv
// Sequencer between the EX stage and a multi-cycle divider: resolves special cases,
// reuses the last quotient/remainder pair, and drains the divider on flush.
module div_ctrl #(
    parameter int unsigned WIDTH    = 32,
    parameter bit          CACHE_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             req_ready,
    input  logic             flush,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_data,
    output logic             ctrl_busy,
    output logic             div_start,
    output logic             div_sign,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic             div_busy,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FAST,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO,
        S_DONE,
        S_DRAIN_HI,
        S_DRAIN_LO
    } state_t;

    state_t state, state_nxt;

    logic             rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rmd_q;
    logic             resp_pend;
    logic [WIDTH-1:0] resp_hold;
    logic             cache_vld;
    logic [WIDTH-1:0] tag_a;
    logic [WIDTH-1:0] tag_b;
    logic             tag_sign;
    logic [WIDTH-1:0] cache_quo;
    logic [WIDTH-1:0] cache_rmd;

    logic             accept;
    logic             req_sign;
    logic             is_zero;
    logic             is_ovf;
    logic             is_hit;
    logic             cap_div;
    logic             cache_clr;
    logic [WIDTH-1:0] result;

    // Request decode; DIV/REM are the signed ops (op[0] == 0)
    assign accept   = (state == S_IDLE) && req_valid && !flush;
    assign req_sign = ~req_op[0];
    assign is_zero  = (req_b == '0);
    assign is_ovf   = req_sign && (req_a == MIN_NEG) && (req_b == '1);
    assign is_hit   = CACHE_EN && cache_vld && (req_a == tag_a) && (req_b == tag_b)
                      && (req_sign == tag_sign);

    assign result     = rem_q ? rmd_q : quo_q;
    assign resp_valid = resp_pend && !flush;
    assign resp_data  = resp_valid ? result : resp_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cap_div   = 1'b0;
        cache_clr = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (is_zero || is_ovf || is_hit) ? S_FAST : S_START;
                end
            end
            S_FAST, S_DONE: begin
                state_nxt = S_IDLE;
            end
            S_START: begin
                // the launch pulse is already out; a flush here must still drain
                cache_clr = flush;
                state_nxt = flush ? S_DRAIN_HI : S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (flush) begin
                    cache_clr = 1'b1;
                    state_nxt = div_busy ? S_DRAIN_LO : S_DRAIN_HI;
                end else if (div_busy) begin
                    state_nxt = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (flush) begin
                    cache_clr = 1'b1;
                    state_nxt = div_busy ? S_DRAIN_LO : S_IDLE;
                end else if (!div_busy) begin
                    cap_div   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DRAIN_HI: begin
                if (div_busy) begin
                    state_nxt = S_DRAIN_LO;
                end
            end
            S_DRAIN_LO: begin
                if (!div_busy) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand latch, result selection and last-result cache
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready    <= 1'b1;
            ctrl_busy    <= 1'b0;
            div_start    <= 1'b0;
            div_sign     <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            rem_q        <= 1'b0;
            quo_q        <= '0;
            rmd_q        <= '0;
            resp_pend    <= 1'b0;
            resp_hold    <= '0;
            cache_vld    <= 1'b0;
            tag_a        <= '0;
            tag_b        <= '0;
            tag_sign     <= 1'b0;
            cache_quo    <= '0;
            cache_rmd    <= '0;
        end else begin
            req_ready <= (state_nxt == S_IDLE);
            ctrl_busy <= (state_nxt != S_IDLE);
            div_start <= (state_nxt == S_START);
            resp_pend <= (state_nxt == S_FAST) || (state_nxt == S_DONE);

            if (accept) begin
                div_dividend <= req_a;
                div_divisor  <= req_b;
                div_sign     <= req_sign;
                rem_q        <= req_op[1];
                if (is_zero) begin
                    quo_q <= '1;
                    rmd_q <= req_a;
                end else if (is_ovf) begin
                    quo_q <= req_a;
                    rmd_q <= '0;
                end else if (is_hit) begin
                    quo_q <= cache_quo;
                    rmd_q <= cache_rmd;
                end
            end

            if (cap_div) begin
                quo_q     <= div_quotient;
                rmd_q     <= div_remainder;
                cache_vld <= CACHE_EN;
                tag_a     <= div_dividend;
                tag_b     <= div_divisor;
                tag_sign  <= div_sign;
                cache_quo <= div_quotient;
                cache_rmd <= div_remainder;
            end

            if (cache_clr) begin
                cache_vld <= 1'b0;
            end

            if (resp_valid) begin
                resp_hold <= result;
            end
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: one caching and one non-caching instance, each
// driving a small behavioural divider stub.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rv0 = 1'b0;
    logic        rv1 = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        flush = 1'b0;

    logic        rdy0, rsv0, cb0, ds0, dsg0, db0;
    logic [31:0] rsd0, dd0, dv0, dq0, dr0;
    logic        rdy1, rsv1, cb1, ds1, dsg1, db1;
    logic [31:0] rsd1, dd1, dv1, dq1, dr1;

    int total = 0;
    int bad   = 0;
    int cnt0  = 0;
    int cnt1  = 0;
    logic last_sign = 1'b0;

    always #5 clk = ~clk;

    div_ctrl #(.WIDTH(32), .CACHE_EN(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(rv0), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_ready(rdy0), .flush(flush), .resp_valid(rsv0), .resp_data(rsd0), .ctrl_busy(cb0),
        .div_start(ds0), .div_sign(dsg0), .div_dividend(dd0), .div_divisor(dv0),
        .div_busy(db0), .div_quotient(dq0), .div_remainder(dr0)
    );

    div_ctrl #(.WIDTH(32), .CACHE_EN(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_ready(rdy1), .flush(flush), .resp_valid(rsv1), .resp_data(rsd1), .ctrl_busy(cb1),
        .div_start(ds1), .div_sign(dsg1), .div_dividend(dd1), .div_divisor(dv1),
        .div_busy(db1), .div_quotient(dq1), .div_remainder(dr1)
    );

    // Divider stub arithmetic: {quotient, remainder}
    function automatic logic [63:0] stub_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {a, 32'd0};
        if (s) return {32'(sa / sb), 32'(sa % sb)};
        return {a / b, a % b};
    endfunction

    // Busy rises the cycle after start, stays high five cycles, then falls with the result
    always @(posedge clk) begin
        if (ds0) begin
            cnt0 <= 5;
            {dq0, dr0} <= stub_div(dsg0, dd0, dv0);
        end else if (cnt0 != 0) begin
            cnt0 <= cnt0 - 1;
        end
        if (ds1) begin
            cnt1 <= 5;
            {dq1, dr1} <= stub_div(dsg1, dd1, dv1);
        end else if (cnt1 != 0) begin
            cnt1 <= cnt1 - 1;
        end
    end
    assign db0 = (cnt0 != 0);
    assign db1 = (cnt1 != 0);

    function automatic logic f_rdy(input int i);   return (i == 0) ? rdy0 : rdy1; endfunction
    function automatic logic f_rv(input int i);    return (i == 0) ? rsv0 : rsv1; endfunction
    function automatic logic [31:0] f_rd(input int i); return (i == 0) ? rsd0 : rsd1; endfunction
    function automatic logic f_start(input int i); return (i == 0) ? ds0 : ds1; endfunction
    function automatic logic f_sign(input int i);  return (i == 0) ? dsg0 : dsg1; endfunction
    function automatic logic f_busy(input int i);  return (i == 0) ? db0 : db1; endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // One request through instance idx; checks data, launch count and latency
    task automatic run_op(input int idx, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit exp_launch,
                          input string tag);
        int n, starts, fall_at;
        bit busy_seen, got;
        logic [31:0] data;
        n = 0; starts = 0; fall_at = -1; busy_seen = 1'b0; got = 1'b0; data = '0;
        @(negedge clk);
        chk({tag, "_ready"}, 64'(f_rdy(idx)), 64'd1);
        req_op = op; req_a = a; req_b = b;
        if (idx == 0) rv0 = 1'b1; else rv1 = 1'b1;
        @(posedge clk);
        #1;
        rv0 = 1'b0; rv1 = 1'b0; req_a = ~a; req_b = ~b;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (f_start(idx)) begin
                starts++;
                last_sign = f_sign(idx);
            end
            if (f_busy(idx)) busy_seen = 1'b1;
            else if (busy_seen && fall_at < 0) fall_at = n;
            if (f_rv(idx)) begin
                got = 1'b1;
                data = f_rd(idx);
            end
        end
        chk({tag, "_resp"}, 64'(got), 64'd1);
        chk({tag, "_data"}, 64'(data), 64'(exp));
        chk({tag, "_launch"}, 64'(starts), exp_launch ? 64'd1 : 64'd0);
        chk({tag, "_lat"}, 64'(n), exp_launch ? 64'(fall_at + 1) : 64'd1);
    endtask

    initial begin
        int n, rcnt, starts, fall_at;
        bit busy_seen;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(rdy0), 64'd1);
        chk("rst_busy", 64'(cb0), 64'd0);
        chk("rst_resp", {31'd0, rsv0, rsd0}, 64'd0);
        chk("rst_div", {30'd0, ds0, dsg0, dd0 | dv0}, 64'd0);

        // Unsigned launch, then remainder served from the cache
        run_op(0, 2'b01, 32'hFFFF_FEA3, 32'd26, 32'd165191036, 1'b1, "divu");
        chk("divu_sign", 64'(last_sign), 64'd0);
        run_op(0, 2'b11, 32'hFFFF_FEA3, 32'd26, 32'd11, 1'b0, "remu_hit");

        // Same operand bits but signed: must miss the unsigned cache entry
        run_op(0, 2'b00, 32'hFFFF_FEA3, 32'd26, 32'hFFFF_FFF3, 1'b1, "div_neg");
        chk("div_neg_sign", 64'(last_sign), 64'd1);
        run_op(1, 2'b00, 32'hFFFF_FEA3, 32'd26, 32'hFFFF_FFF3, 1'b1, "nc_div");
        run_op(1, 2'b10, 32'hFFFF_FEA3, 32'd26, 32'hFFFF_FFF5, 1'b1, "nc_rem");

        // Divide by zero
        run_op(0, 2'b01, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, "divu_z");
        run_op(0, 2'b11, 32'd7, 32'd0, 32'd7, 1'b0, "remu_z");
        run_op(0, 2'b00, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b0, "div_z");
        run_op(0, 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b0, "rem_z");

        // Signed overflow, then the earlier signed entry still hits
        run_op(0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "div_ovf");
        run_op(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, "rem_ovf");
        run_op(0, 2'b00, 32'hFFFF_FEA3, 32'd26, 32'hFFFF_FFF3, 1'b0, "div_hit");

        // Flush during FAST: pulse suppressed, data holds the previous result
        @(negedge clk);
        req_op = 2'b01; req_a = 32'd7; req_b = 32'd0; rv0 = 1'b1;
        @(posedge clk);
        #1;
        rv0 = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("fast_flush_valid", 64'(rsv0), 64'd0);
        chk("fast_flush_hold", 64'(rsd0), 64'hFFFF_FFF3);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("fast_flush_after", {31'd0, rsv0, 31'd0, cb0}, 64'd0);

        // Flush in IDLE blocks acceptance
        rv0 = 1'b1; flush = 1'b1; req_op = 2'b01; req_a = 32'd9; req_b = 32'd3;
        @(negedge clk);
        chk("idle_flush_busy", 64'(cb0), 64'd0);
        rv0 = 1'b0; flush = 1'b0;

        // Flush in WAIT_LO: drain, no response, busy until the divider finishes
        @(negedge clk);
        req_op = 2'b00; req_a = 32'd100; req_b = 32'd7; rv0 = 1'b1;
        @(posedge clk);
        #1;
        rv0 = 1'b0;
        n = 0; rcnt = 0; starts = 0; fall_at = -1; busy_seen = 1'b0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (ds0) starts++;
            if (rsv0) rcnt++;
            if (db0) busy_seen = 1'b1;
            else if (busy_seen && fall_at < 0) fall_at = n;
            if (n == 3) flush = 1'b1;
            if (n == 4) flush = 1'b0;
            if (!cb0) break;
        end
        chk("drain_resp", 64'(rcnt), 64'd0);
        chk("drain_launch", 64'(starts), 64'd1);
        chk("drain_end", 64'(n), 64'(fall_at + 1));
        run_op(0, 2'b10, 32'd100, 32'd7, 32'd2, 1'b1, "rem_post_drain");

        // Reset in WAIT_LO
        @(negedge clk);
        req_op = 2'b01; req_a = 32'd100; req_b = 32'd7; rv0 = 1'b1;
        @(posedge clk);
        #1;
        rv0 = 1'b0;
        n = 0;
        while (n < 4) begin
            @(negedge clk);
            n++;
            if (n == 3) rst = 1'b1;
        end
        chk("mid_rst_ready", 64'(rdy0), 64'd1);
        chk("mid_rst_busy", 64'(cb0), 64'd0);
        chk("mid_rst_resp", {31'd0, rsv0, rsd0}, 64'd0);
        chk("mid_rst_div", {30'd0, ds0, dsg0, dd0 | dv0}, 64'd0);
        rst = 1'b0;
        rcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsv0 || cb0) rcnt++;
        end
        chk("mid_rst_quiet", 64'(rcnt), 64'd0);
        run_op(0, 2'b01, 32'd10, 32'd3, 32'd3, 1'b1, "divu_post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
